instr_fetch: RTL and testbench

- Producer side of the decoder's instruction interface.
- Issues word-aligned fetches to instruction memory over a req/gnt/rvalid handshake and buffers returned words in a small FIFO.
- Presents them, with their PC, to the decode stage over a valid/ready handshake.
- Handles PC redirects (branch/jump) by flushing buffered words and discarding in-flight responses.

---
 rtl/rv32i.sv | 42 ++++
 rtl/fetch_fifo.sv | 57 +++++
 rtl/instr_fetch.sv | 134 +++++++++++++
 tb/tb_instr_fetch.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i.sv
// Shared RV32I types for the front end: instruction views, fetch states
// and the fetch buffer entry.
package rv32i;

  localparam logic [31:0] RV32I_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } rv32i_r_t;

  typedef struct packed {
    logic [11:0] imm;
    logic [4:0]  rs1;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [6:0]  opcode;
  } rv32i_i_t;

  typedef union packed {
    logic [31:0] raw;
    rv32i_r_t    r;
    rv32i_i_t    i;
  } rv32i_inst_u;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT
  } ifu_state_e;

  typedef struct packed {
    rv32i_inst_u instr;
    logic [31:0] pc;
    logic        fault;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries; registered head, no bypass.
// Flush beats push; push and pop may coincide at any occupancy.
module fetch_fifo
  import rv32i::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           din,
  output logic [$clog2(DEPTH):0] count,
  output fetch_entry_t           head,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && ((count != FULL) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: credit-limited requests to imem, in-order
// response buffering, redirect flush and halt on bus error.
module instr_fetch
  import rv32i::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        imem_err,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output rv32i_inst_u instr,
  output logic [31:0] instr_pc,
  output logic        instr_fault
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  ifu_state_e    state;
  ifu_state_e    state_nxt;
  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [31:0]   new_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] out_nxt;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   credit;
  logic          grant;
  logic          accept;
  logic          push;
  logic          fault_rsp;
  logic          fifo_empty;
  fetch_entry_t  din;
  fetch_entry_t  head;
  logic          unused_pc_lsb;

  assign unused_pc_lsb = ^redirect_pc[1:0];
  assign new_pc        = {redirect_pc[31:2], 2'b00};

  assign credit    = {1'b0, outstanding} + {1'b0, fifo_count};
  assign imem_req  = (state == RUN) && !redirect_valid &&
                     (credit < (CW+1)'(FIFO_DEPTH));
  assign imem_addr = fetch_pc;

  assign grant     = imem_req && imem_gnt;
  assign accept    = imem_rvalid && (drop_cnt == '0);
  assign push      = accept && !redirect_valid;
  assign fault_rsp = push && imem_err;
  assign out_nxt   = outstanding + CW'(grant) - CW'(imem_rvalid);

  assign din.instr = imem_err ? rv32i_inst_u'(RV32I_NOP) :
                                rv32i_inst_u'(imem_rdata);
  assign din.pc    = resp_pc;
  assign din.fault = imem_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      BOOT:    state_nxt = RUN;
      RUN:     if (fault_rsp) state_nxt = HALT;
      HALT:    state_nxt = HALT;
      default: state_nxt = BOOT;
    endcase
    if (redirect_valid) state_nxt = RUN;
  end

  // A redirect orphans every pending response; an error orphans the rest.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= out_nxt;
      if (redirect_valid) begin
        fetch_pc <= new_pc;
        resp_pc  <= new_pc;
        drop_cnt <= outstanding - CW'(imem_rvalid);
      end else begin
        if (grant) fetch_pc <= fetch_pc + 32'd4;
        if (push)  resp_pc  <= resp_pc + 32'd4;
        if (fault_rsp) begin
          drop_cnt <= out_nxt;
        end else if (imem_rvalid && (drop_cnt != '0)) begin
          drop_cnt <= drop_cnt - 1'b1;
        end
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (instr_valid && instr_ready),
    .flush (redirect_valid),
    .din   (din),
    .count (fifo_count),
    .head  (head),
    .empty (fifo_empty)
  );

  assign instr_valid = !fifo_empty;
  assign instr       = head.instr;
  assign instr_pc    = head.pc;
  assign instr_fault = head.fault;

  rsp_without_req: assert property (
    @(posedge clk) disable iff (!rst_n)
    imem_rvalid |-> (outstanding != '0)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: imem model with grant limit and response hold,
// expected-instruction queue checked at the decoder handshake.
module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
    logic        fault;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_err = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_fault;

  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q[$];
  logic [31:0] pend[$];
  logic [31:0] grants[$];
  logic        gnt_en = 1'b0;
  int          gnt_limit = 0;
  logic        resp_en = 1'b1;
  logic        err_on = 1'b0;
  logic [31:0] err_addr = '0;

  instr_fetch #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .imem_err       (imem_err),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_fault    (instr_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0000_0093 + (a << 5);
  endfunction

  function automatic void push_exp(input logic [31:0] pc, input logic f);
    exp_t e;
    e.pc    = pc;
    e.word  = f ? NOP : mem_word(pc);
    e.fault = f;
    exp_q.push_back(e);
  endfunction

  // Handshakes are sampled mid-cycle, when everything has settled.
  always @(negedge clk) begin
    if (rst_n && imem_req && imem_gnt) begin
      pend.push_back(imem_addr);
      grants.push_back(imem_addr);
    end
  end

  always @(posedge clk) begin
    logic [31:0] a;
    #2;
    if (!rst_n) begin
      pend.delete();
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      imem_err    = 1'b0;
    end else if (resp_en && pend.size() != 0) begin
      a = pend.pop_front();
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(a);
      imem_err    = err_on && (a == err_addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      imem_err    = 1'b0;
    end
    imem_gnt = gnt_en && (grants.size() < gnt_limit);
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && instr_valid && instr_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got pc %h instr %h, required none",
                 instr_pc, instr);
      end else begin
        e = exp_q.pop_front();
        if (instr_pc !== e.pc || instr !== e.word ||
            instr_fault !== e.fault) begin
          errors++;
          $display("FAIL sb_instr: got pc %h instr %h fault %b, required pc %h instr %h fault %b",
                   instr_pc, instr, instr_fault, e.pc, e.word, e.fault);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Returns at the start of cycle 0, the first cycle with rst_n high.
  task automatic do_reset();
    cyc();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b1;
    gnt_en         = 1'b0;
    gnt_limit      = 0;
    resp_en        = 1'b1;
    err_on         = 1'b0;
    grants.delete();
    exp_q.delete();
    repeat (2) cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    gnt_en    = 1'b1;
    gnt_limit = 3;
    push_exp(32'h0, 1'b0);
    push_exp(32'h4, 1'b0);
    push_exp(32'h8, 1'b0);
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0 ||
        instr_pc !== 32'h0 || instr_fault !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got req %b valid %b instr %h pc %h fault %b, required all 0",
               imem_req, instr_valid, instr, instr_pc, instr_fault);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL first_req: got req %b addr %h, required 1 00000000",
               imem_req, imem_addr);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL early_valid: got %b, required 0", instr_valid);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
      errors++;
      $display("FAIL first_valid: got valid %b pc %h, required 1 00000000",
               instr_valid, instr_pc);
    end
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) cyc();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_basic: got %0d left, required 0", exp_q.size());
    end
    repeat (3) cyc();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (grants.size() != 3 || grants[i] !== 32'(4 * i)) begin
        errors++;
        $display("FAIL grant_addr_%0d: got %h (of %0d), required %h",
                 i, grants[i], grants.size(), 32'(4 * i));
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    gnt_en      = 1'b1;
    gnt_limit   = 4;
    instr_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_exp(32'(4 * i), 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i >= 3) begin
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h0 ||
            instr !== mem_word(32'h0)) begin
          errors++;
          $display("FAIL stall_hold_c%0d: got valid %b pc %h instr %h, required 1 00000000 %h",
                   i, instr_valid, instr_pc, instr, mem_word(32'h0));
        end
      end
      if (i >= 5) begin
        checks++;
        if (imem_req !== 1'b0) begin
          errors++;
          $display("FAIL stall_credit_c%0d: got req %b, required 0", i, imem_req);
        end
      end
      cyc();
    end
    checks++;
    if (grants.size() != 2) begin
      errors++;
      $display("FAIL stall_grants: got %0d, required 2", grants.size());
    end
    instr_ready = 1'b1;
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) cyc();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_stall: got %0d left, required 0", exp_q.size());
    end
  endtask

  task automatic test_redirect();
    do_reset();
    gnt_en    = 1'b1;
    gnt_limit = 2;
    push_exp(32'h0, 1'b0);
    push_exp(32'h4, 1'b0);
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) cyc();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_pre_redir: got %0d left, required 0", exp_q.size());
    end
    resp_en   = 1'b0;
    gnt_limit = 4;
    for (int i = 0; i < 10 && grants.size() < 4; i++) cyc();
    checks++;
    if (grants.size() != 4 || grants[2] !== 32'h8 || grants[3] !== 32'hC) begin
      errors++;
      $display("FAIL redir_inflight: got %0d grants, required 4 ending 8,c",
               grants.size());
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0102;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("FAIL redir_req: got %b, required 0", imem_req);
    end
    cyc();
    redirect_valid = 1'b0;
    resp_en        = 1'b1;
    gnt_limit      = 6;
    push_exp(32'h100, 1'b0);
    push_exp(32'h104, 1'b0);
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL redir_flush: got valid %b, required 0", instr_valid);
    end
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) cyc();
    checks++;
    if (exp_q.size() != 0 || grants.size() < 5 || grants[4] !== 32'h100) begin
      errors++;
      $display("FAIL redir_resume: got %0d left, next addr %h, required 0 left, 00000100",
               exp_q.size(), grants[4]);
    end
    repeat (3) cyc();
  endtask

  task automatic test_collide();
    do_reset();
    gnt_en    = 1'b1;
    gnt_limit = 2;
    push_exp(32'h0, 1'b0);
    repeat (3) cyc();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0040;
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL collide_setup: got valid %b req %b, required 1 0",
               instr_valid, imem_req);
    end
    cyc();
    redirect_valid = 1'b0;
    gnt_limit      = 4;
    push_exp(32'h40, 1'b0);
    push_exp(32'h44, 1'b0);
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL collide_stale: got valid %b, required 0", instr_valid);
    end
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) cyc();
    checks++;
    if (exp_q.size() != 0 || grants.size() != 4 || grants[2] !== 32'h40) begin
      errors++;
      $display("FAIL collide_resume: got %0d left, %0d grants, addr %h, required 0, 4, 00000040",
               exp_q.size(), grants.size(), grants[2]);
    end
    repeat (3) cyc();
  endtask

  task automatic test_error();
    do_reset();
    gnt_en    = 1'b1;
    gnt_limit = 100;
    err_on    = 1'b1;
    err_addr  = 32'h10;
    for (int i = 0; i < 4; i++) push_exp(32'(4 * i), 1'b0);
    push_exp(32'h10, 1'b1);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) cyc();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_error: got %0d left, required 0", exp_q.size());
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL halt_c%0d: got req %b valid %b, required 0 0",
                 i, imem_req, instr_valid);
      end
      cyc();
    end
    checks++;
    if (grants.size() != 6 || grants[5] !== 32'h14) begin
      errors++;
      $display("FAIL halt_grants: got %0d last %h, required 6 last 00000014",
               grants.size(), grants[grants.size() - 1]);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    gnt_limit      = 8;
    cyc();
    redirect_valid = 1'b0;
    push_exp(32'h200, 1'b0);
    push_exp(32'h204, 1'b0);
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) cyc();
    checks++;
    if (exp_q.size() != 0 || grants.size() != 8 || grants[6] !== 32'h200) begin
      errors++;
      $display("FAIL err_resume: got %0d left, %0d grants, required 0, 8 from 00000200",
               exp_q.size(), grants.size());
    end
    repeat (3) cyc();
  endtask

  task automatic test_wrap();
    do_reset();
    gnt_en    = 1'b1;
    gnt_limit = 0;
    cyc();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    cyc();
    redirect_valid = 1'b0;
    gnt_limit      = 2;
    push_exp(32'hFFFF_FFFC, 1'b0);
    push_exp(32'h0000_0000, 1'b0);
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) cyc();
    checks++;
    if (exp_q.size() != 0 || grants.size() != 2 ||
        grants[0] !== 32'hFFFF_FFFC || grants[1] !== 32'h0) begin
      errors++;
      $display("FAIL wrap: got %0d left, %0d grants, addrs %h %h, required 0, 2, fffffffc 00000000",
               exp_q.size(), grants.size(), grants[0], grants[1]);
    end
    repeat (3) cyc();
  endtask

  initial begin
    test_reset();
    test_stall();
    test_redirect();
    test_collide();
    test_error();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
